xbar_ingress_queue: RTL and testbench

- Upstream feeder for the 4x4 crossbar switch.
- Buffers cells arriving on four independent ingress ports in per-port FIFOs.
- Runs the req/start handshake with the switch, then drives one cell per port per slot on iport0..iport3 for four consecutive slot cycles.
- Builds the 15-bit crossbar cell: bit14 valid, bit13 0, [12:11] dest, bit10 0, [9:8] src = port index, [7:0] payload.

---
 rtl/xbar_ingress_queue_if.sv | 25 ++
 rtl/xbar_ingress_queue.sv | 106 ++++++++++
 tb/tb_xbar_ingress_queue.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_ingress_queue_if.sv
// Ingress write ports plus the req/start handshake and cell outputs toward the crossbar.
// Combinational bundle only: no latency of its own.
// Backpressure: per-port wr_ready toward the feeders; req gates frame issue from the switch.
interface xbar_ingress_queue_if;
    logic [3:0]  wr_valid;
    logic [3:0]  wr_ready;
    logic [7:0]  wr_dest;
    logic [31:0] wr_pld;
    logic        req;
    logic        start;
    logic [14:0] iport0;
    logic [14:0] iport1;
    logic [14:0] iport2;
    logic [14:0] iport3;

    modport master (
        output wr_valid, wr_dest, wr_pld, req,
        input  wr_ready, start, iport0, iport1, iport2, iport3
    );

    modport slave (
        input  wr_valid, wr_dest, wr_pld, req,
        output wr_ready, start, iport0, iport1, iport2, iport3
    );
endinterface

// File: rtl/xbar_ingress_queue.sv
// Per-port ingress FIFOs feeding a 4x4 crossbar, one cell per port per slot over four slots.
// Latency: slot-0 cells appear 1 cycle after the req&start edge; frame occupies 4 cycles.
// Backpressure: wr_ready[p] drops when FIFO p is full; same-cycle pops do not reopen it.
module xbar_ingress_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    xbar_ingress_queue_if.slave   bus,
    output logic [4*(AW+1)-1:0]   level,
    output logic [7:0]            frame_cnt
);
    typedef enum logic [2:0] {IDLE, S0, S1, S2, S3} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [9:0]    mem    [4][DEPTH];
    logic [AW-1:0] wr_ptr [4];
    logic [AW-1:0] rd_ptr [4];
    logic [AW:0]   cnt    [4];
    logic [14:0]   iport_q[4];
    logic [3:0]    push;
    logic [3:0]    pop;
    logic          any_queued;
    logic          hs;
    logic          load;

    always_comb begin
        level        = '0;
        any_queued   = 1'b0;
        bus.wr_ready = 4'h0;
        for (int p = 0; p < 4; p++) begin
            level[p*(AW+1) +: AW+1] = cnt[p];
            any_queued              = any_queued | (cnt[p] != '0);
            bus.wr_ready[p]         = (cnt[p] != FULL);
        end
        bus.start = (state == IDLE) && any_queued;
        hs        = bus.start && bus.req;
        // Each slot load re-samples occupancy, so late arrivals join the frame.
        load      = hs || (state == S0) || (state == S1) || (state == S2);
        for (int p = 0; p < 4; p++) begin
            push[p] = bus.wr_valid[p] && bus.wr_ready[p];
            pop[p]  = load && (cnt[p] != '0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = S0;
            S0:      state_nxt = S1;
            S1:      state_nxt = S2;
            S2:      state_nxt = S3;
            S3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= {bus.wr_dest[2*p +: 2], bus.wr_pld[8*p +: 8]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 4; p++) begin
                wr_ptr[p]  <= '0;
                rd_ptr[p]  <= '0;
                cnt[p]     <= '0;
                iport_q[p] <= '0;
            end
            frame_cnt <= '0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + AW'(1);
                case ({push[p], pop[p]})
                    2'b10:   cnt[p] <= cnt[p] + (AW+1)'(1);
                    2'b01:   cnt[p] <= cnt[p] - (AW+1)'(1);
                    default: cnt[p] <= cnt[p];
                endcase
                if (load) begin
                    iport_q[p] <= pop[p] ? {1'b1, 1'b0, mem[p][rd_ptr[p]][9:8], 1'b0, 2'(p),
                                            mem[p][rd_ptr[p]][7:0]}
                                         : 15'd0;
                end else if (state == S3) begin
                    iport_q[p] <= 15'd0;
                end
            end
            if (state == S3) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign bus.iport0 = iport_q[0];
    assign bus.iport1 = iport_q[1];
    assign bus.iport2 = iport_q[2];
    assign bus.iport3 = iport_q[3];
endmodule

// File: tb/tb_xbar_ingress_queue.sv
// Directed bench for xbar_ingress_queue: table-driven single-port frame plus multi-cycle sequences.
// Outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure exercised through a full FIFO and continuous pushes across pointer wrap.
module tb_xbar_ingress_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] level;
    logic [7:0]  frame_cnt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    xbar_ingress_queue_if bus();

    xbar_ingress_queue #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .level     (level),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [3:0]  wv;
        logic [7:0]  wd;
        logic [31:0] wp;
        logic        req;
        logic        e_start;
        logic [3:0]  e_rdy;
        logic [15:0] e_lvl;
        logic [14:0] e_ip0;
        logic [7:0]  e_fc;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] mk(input int p, input int d, input int pld);
        return {1'b1, 1'b0, 2'(d), 1'b0, 2'(p), 8'(pld)};
    endfunction

    function automatic logic [3:0] lvl(input int p);
        return level[4*p +: 4];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_valid = 4'h0;
        bus.wr_dest  = 8'h0;
        bus.wr_pld   = 32'h0;
        bus.req      = 1'b0;
        rst          = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, hs, busy;
        logic will_push, will_hs;

        tv[0] = '{4'h1, 8'h02, 32'hA1, 1'b0, 1'b1, 4'hF, 16'h0001, 15'h0000, 8'd0};
        tv[1] = '{4'h1, 8'h03, 32'hA2, 1'b0, 1'b1, 4'hF, 16'h0002, 15'h0000, 8'd0};
        tv[2] = '{4'h0, 8'h00, 32'h00, 1'b1, 1'b0, 4'hF, 16'h0001, 15'h50A1, 8'd0};
        tv[3] = '{4'h0, 8'h00, 32'h00, 1'b1, 1'b0, 4'hF, 16'h0000, 15'h58A2, 8'd0};
        tv[4] = '{4'h0, 8'h00, 32'h00, 1'b1, 1'b0, 4'hF, 16'h0000, 15'h0000, 8'd0};
        tv[5] = '{4'h0, 8'h00, 32'h00, 1'b1, 1'b0, 4'hF, 16'h0000, 15'h0000, 8'd0};
        tv[6] = '{4'h0, 8'h00, 32'h00, 1'b0, 1'b0, 4'hF, 16'h0000, 15'h0000, 8'd1};
        tv[7] = '{4'h0, 8'h00, 32'h00, 1'b1, 1'b0, 4'hF, 16'h0000, 15'h0000, 8'd1};

        // Idle after reset with req held high.
        do_reset();
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_fc", 32'(frame_cnt), 32'h0);
        bus.req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_start", 32'(bus.start), 32'h0);
            chk("idle_iport", 32'(bus.iport0 | bus.iport1 | bus.iport2 | bus.iport3), 32'h0);
            chk("idle_rdy", 32'(bus.wr_ready), 32'hF);
        end

        // Two cells on port 0, one frame.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.wr_valid = tv[i].wv;
            bus.wr_dest  = tv[i].wd;
            bus.wr_pld   = tv[i].wp;
            bus.req      = tv[i].req;
            tick();
            chk($sformatf("vec%0d_start", i), 32'(bus.start), 32'(tv[i].e_start));
            chk($sformatf("vec%0d_rdy", i), 32'(bus.wr_ready), 32'(tv[i].e_rdy));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].e_lvl));
            chk($sformatf("vec%0d_ip0", i), 32'(bus.iport0), 32'(tv[i].e_ip0));
            chk($sformatf("vec%0d_ip123", i), 32'(bus.iport1 | bus.iport2 | bus.iport3), 32'h0);
            chk($sformatf("vec%0d_fc", i), 32'(frame_cnt), 32'(tv[i].e_fc));
        end

        // Five cells each on ports 1 and 3; one frame carries four of each.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            bus.wr_valid = 4'b1010;
            bus.wr_dest  = {2'(3 - (k % 4)), 2'b00, 2'(k % 4), 2'b00};
            bus.wr_pld   = {8'(8'h30 + k), 8'h00, 8'(8'h10 + k), 8'h00};
            tick();
        end
        bus.wr_valid = 4'h0;
        bus.req      = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            bus.req = 1'b0;
            chk($sformatf("p13_s%0d_ip1", s), 32'(bus.iport1), 32'(mk(1, s, 8'h10 + s)));
            chk($sformatf("p13_s%0d_ip3", s), 32'(bus.iport3), 32'(mk(3, 3 - s, 8'h30 + s)));
            chk($sformatf("p13_s%0d_ip02", s), 32'(bus.iport0 | bus.iport2), 32'h0);
        end
        tick();
        chk("p13_lvl1", 32'(lvl(1)), 32'd1);
        chk("p13_lvl3", 32'(lvl(3)), 32'd1);
        chk("p13_start", 32'(bus.start), 32'h1);
        chk("p13_fc", 32'(frame_cnt), 32'd1);

        // Fill port 2; pushes while full (including on the pop edge) are dropped.
        do_reset();
        bus.wr_valid = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            bus.wr_dest = 8'(k % 4) << 4;
            bus.wr_pld  = 32'(8'h20 + k) << 16;
            tick();
        end
        chk("full_lvl", 32'(lvl(2)), 32'd8);
        chk("full_rdy", 32'(bus.wr_ready), 32'hB);
        bus.wr_pld = 32'hFF << 16;
        tick();
        chk("full_drop_lvl", 32'(lvl(2)), 32'd8);
        chk("full_drop_rdy", 32'(bus.wr_ready), 32'hB);
        bus.wr_pld = 32'hEE << 16;
        bus.req    = 1'b1;
        tick();
        chk("full_pop_lvl", 32'(lvl(2)), 32'd7);
        chk("full_pop_rdy", 32'(bus.wr_ready), 32'hF);
        chk("full_s0_ip2", 32'(bus.iport2), 32'(mk(2, 0, 8'h20)));
        bus.wr_valid = 4'h0;
        bus.req      = 1'b0;
        for (int s = 1; s < 4; s++) begin
            tick();
            chk($sformatf("full_s%0d_ip2", s), 32'(bus.iport2), 32'(mk(2, s, 8'h20 + s)));
        end
        tick();
        chk("full_mid_lvl", 32'(lvl(2)), 32'd4);
        bus.req = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            bus.req = 1'b0;
            chk($sformatf("full2_s%0d_ip2", s), 32'(bus.iport2), 32'(mk(2, s, 8'h24 + s)));
        end
        tick();
        chk("full_end_lvl", 32'(lvl(2)), 32'd0);
        chk("full_end_start", 32'(bus.start), 32'h0);

        // Continuous pushes on port 0 with req toggling; order kept across wrap.
        do_reset();
        sent = 0;
        got  = 0;
        hs   = 0;
        busy = 0;
        for (int cyc = 0; cyc < 400 && got < 24; cyc++) begin
            if (busy > 0) begin
                chk("wrap_no_start", 32'(bus.start), 32'h0);
                busy--;
            end
            if (bus.iport0[14]) begin
                chk($sformatf("wrap_cell%0d", got), 32'(bus.iport0), 32'(mk(0, got % 4, got)));
                got++;
            end
            bus.wr_valid = {3'b000, sent < 24};
            bus.wr_dest  = 8'(sent % 4);
            bus.wr_pld   = 32'(sent);
            bus.req      = cyc[0];
            will_push    = (sent < 24) && bus.wr_ready[0];
            will_hs      = bus.start && bus.req;
            tick();
            if (will_push) sent++;
            if (will_hs) begin
                hs++;
                busy = 4;
            end
        end
        chk("wrap_count", 32'(got), 32'd24);
        bus.wr_valid = 4'h0;
        bus.req      = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("wrap_fc", 32'(frame_cnt), 32'(8'(hs)));
        chk("wrap_lvl", 32'(level), 32'h0);

        // Reset asserted in S1 with cells queued.
        do_reset();
        bus.wr_valid = 4'b0011;
        bus.wr_dest  = 8'h05;
        bus.wr_pld   = 32'h0000_4321;
        for (int k = 0; k < 3; k++) tick();
        bus.wr_valid = 4'h0;
        bus.req      = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        chk("mid_pre_valid", 32'(bus.iport0[14]), 32'h1);
        rst = 1'b0;
        #1;
        chk("mid_iport", 32'(bus.iport0 | bus.iport1 | bus.iport2 | bus.iport3), 32'h0);
        chk("mid_level", 32'(level), 32'h0);
        chk("mid_start", 32'(bus.start), 32'h0);
        chk("mid_rdy", 32'(bus.wr_ready), 32'hF);
        chk("mid_fc", 32'(frame_cnt), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("post_start", 32'(bus.start), 32'h0);
        chk("post_level", 32'(level), 32'h0);
        bus.wr_valid = 4'b1000;
        tick();
        bus.wr_valid = 4'h0;
        chk("post_push_start", 32'(bus.start), 32'h1);
        chk("post_push_lvl3", 32'(lvl(3)), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
